resp_misr_compactor: RTL and testbench



---
 rtl/resp_misr_compactor_if.sv | 32 +++
 rtl/resp_misr_compactor.sv | 99 +++++++++
 tb/tb_resp_misr_compactor.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/resp_misr_compactor_if.sv
// Response bus and status handshake between the netlist harness
// and the MISR compactor.
interface resp_misr_compactor_if #(
  parameter int WIDTH = 7,
  parameter int SIG_W = 16,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] num_patterns;
  logic [SIG_W-1:0] golden;
  logic             resp_valid;
  logic [WIDTH-1:0] resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] pat_count;

  modport master (
    output start, num_patterns, golden,
    output resp_valid, resp,
    input  busy, done, pass,
    input  signature, pat_count
  );

  modport slave (
    input  start, num_patterns, golden,
    input  resp_valid, resp,
    output busy, done, pass,
    output signature, pat_count
  );
endinterface

// File: rtl/resp_misr_compactor.sv
// Galois MISR compactor for netlist responses with
// golden-signature compare and start/busy/done status.
module resp_misr_compactor #(
  parameter int             WIDTH = 7,
  parameter int             SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF,
  parameter int             CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  resp_misr_compactor_if.slave s
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] r_golden;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [SIG_W-1:0] w_resp_ext;
  logic [SIG_W-1:0] w_fb;
  logic [SIG_W-1:0] w_next;
  logic             w_last;

  always_comb begin
    w_resp_ext = '0;
    w_resp_ext[WIDTH-1:0] = s.resp;
    w_fb = r_sig[SIG_W-1] ? POLY : '0;
    w_next = {r_sig[SIG_W-2:0], 1'b0}
           ^ w_fb ^ w_resp_ext;
    w_last = (r_cnt == r_n - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sig    <= '0;
      r_golden <= '0;
      r_n      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (s.start) begin
            r_n      <= s.num_patterns;
            r_golden <= s.golden;
            r_sig    <= SEED;
            r_cnt    <= '0;
            // an empty run completes on the same edge
            if (s.num_patterns == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (SEED == s.golden);
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (s.resp_valid) begin
            r_sig <= w_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_next == r_golden);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s.busy      = r_busy;
  assign s.done      = r_done;
  assign s.pass      = r_pass;
  assign s.signature = r_sig;
  assign s.pat_count = r_cnt;

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Scoreboard bench for resp_misr_compactor: default-seed
// instance plus a zero-seed instance for the aliasing case.
module tb_resp_misr_compactor;

  logic clk;
  logic rst_n;

  resp_misr_compactor_if a ();
  resp_misr_compactor_if b ();

  resp_misr_compactor u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (a.slave)
  );

  resp_misr_compactor #(
    .SEED (16'h0000)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_sig;
  logic [15:0] m_g;
  logic [7:0]  m_n;
  logic [7:0]  m_cnt;

  function automatic logic [15:0] misr(
    input logic [15:0] sg,
    input logic [6:0]  r
  );
    logic [15:0] nx;
    nx = sg << 1;
    if (sg[15]) nx = nx ^ 16'h1021;
    nx = nx ^ {9'd0, r};
    return nx;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.sig  = m_sig;
    e.pass = (m_sig == m_g);
    e.cnt  = m_cnt;
    q.push_back(e);
  endtask

  task automatic start_run(
    input logic [7:0]  n,
    input logic [15:0] g
  );
    @(posedge clk); #1;
    a.start = 1'b1;
    a.num_patterns = n;
    a.golden = g;
    @(posedge clk); #1;
    a.start = 1'b0;
    m_sig = 16'hFFFF;
    m_g   = g;
    m_n   = n;
    m_cnt = 8'd0;
    if (n == 8'd0) push_exp();
  endtask

  task automatic beat(
    input logic [6:0] r,
    input int         gap,
    input bit         poke
  );
    for (int i = 0; i < gap; i++) begin
      if (poke && i == 2) begin
        a.start = 1'b1;
        a.num_patterns = 8'd1;
      end
      @(posedge clk); #1;
      a.start = 1'b0;
      chk("gap_sig", a.signature, m_sig);
      chk("gap_cnt", a.pat_count, m_cnt);
    end
    a.start = poke;
    a.resp_valid = 1'b1;
    a.resp = r;
    @(posedge clk); #1;
    a.resp_valid = 1'b0;
    a.start = 1'b0;
    m_sig = misr(m_sig, r);
    m_cnt = m_cnt + 8'd1;
    chk("beat_sig", a.signature, m_sig);
    chk("beat_cnt", a.pat_count, m_cnt);
    if (m_cnt == m_n) push_exp();
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int k;
    k = 0;
    while (!a.done && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_done"}, a.done, 1);
    chk({tag, "_sb"}, q.size() != 0, 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_sig"}, a.signature, e.sig);
      chk({tag, "_pass"}, a.pass, e.pass);
      chk({tag, "_cnt"}, a.pat_count, e.cnt);
      chk({tag, "_busy"}, a.busy, 0);
    end
  endtask

  task automatic idle_pulse(input string tag);
    logic [15:0] s0;
    logic        d0;
    s0 = a.signature;
    d0 = a.done;
    a.resp_valid = 1'b1;
    a.resp = 7'h55;
    @(posedge clk); #1;
    a.resp_valid = 1'b0;
    chk({tag, "_sig"}, a.signature, s0);
    chk({tag, "_done"}, a.done, d0);
    chk({tag, "_busy"}, a.busy, 0);
  endtask

  logic [15:0] g3;
  logic [15:0] g4;

  initial begin
    a.start = 0; a.num_patterns = 0; a.golden = 0;
    a.resp_valid = 0; a.resp = 0;
    b.start = 0; b.num_patterns = 0; b.golden = 0;
    b.resp_valid = 0; b.resp = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sig", a.signature, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_pass", a.pass, 0);
    chk("rst_cnt", a.pat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    idle_pulse("idle_v");

    // single beat, matching golden
    start_run(8'd1, 16'hEFDF);
    chk("r1_busy", a.busy, 1);
    beat(7'h00, 0, 0);
    chk("r1_efdf", a.signature, 16'hEFDF);
    wait_done("r1");

    // back-to-back, mismatching golden
    start_run(8'd1, 16'h0000);
    chk("b2b_done", a.done, 0);
    chk("b2b_seed", a.signature, 16'hFFFF);
    beat(7'h00, 0, 0);
    wait_done("r2");

    // gaps and ignored start mid-run
    g3 = misr(misr(misr(16'hFFFF, 7'h11), 7'h7F), 7'h2A);
    start_run(8'd3, g3);
    beat(7'h11, 5, 1);
    beat(7'h7F, 5, 1);
    beat(7'h2A, 5, 0);
    wait_done("r3");

    // empty run from DONE stays done
    start_run(8'd0, 16'hFFFF);
    chk("n0_busy", a.busy, 0);
    wait_done("n0");
    idle_pulse("done_v");
    start_run(8'd0, 16'h1234);
    wait_done("n0b");

    // asynchronous reset mid-run
    g4 = misr(misr(misr(misr(16'hFFFF, 7'h03),
         7'h40), 7'h5A), 7'h25);
    start_run(8'd4, g4);
    beat(7'h03, 0, 0);
    beat(7'h40, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sig", a.signature, 0);
    chk("ar_busy", a.busy, 0);
    chk("ar_cnt", a.pat_count, 0);
    chk("ar_done", a.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run(8'd4, g4);
    beat(7'h03, 0, 0);
    beat(7'h40, 2, 0);
    beat(7'h5A, 0, 0);
    beat(7'h25, 1, 0);
    wait_done("r4");
    chk("r4_pass1", a.pass, 1);

    // zero-seed aliasing on second instance
    @(posedge clk); #1;
    b.start = 1'b1;
    b.num_patterns = 8'd2;
    b.golden = 16'h0000;
    @(posedge clk); #1;
    b.start = 1'b0;
    b.resp_valid = 1'b1;
    b.resp = 7'h01;
    @(posedge clk); #1;
    chk("z_sig1", b.signature, 16'h0001);
    b.resp = 7'h02;
    @(posedge clk); #1;
    b.resp_valid = 1'b0;
    chk("z_sig2", b.signature, 16'h0000);
    chk("z_done", b.done, 1);
    chk("z_pass", b.pass, 1);
    chk("z_cnt", b.pat_count, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
